// File: rtl/counter_monitor_if.sv
// Signal bundle between an observed up/down counter and its monitor.
// master drives the observed counter signals and clear; slave is the monitor.
interface counter_monitor_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
);
  logic                 mon_rst;
  logic                 mon_enable;
  logic                 mon_direction;
  logic [WIDTH-1:0]     mon_count;
  logic                 clear;
  logic                 locked;
  logic [WIDTH-1:0]     expected;
  logic                 err;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;
  logic [1:0]           err_code;

  modport master (
    output mon_rst, mon_enable, mon_direction, mon_count, clear,
    input  locked, expected, err, err_pulse, err_count, err_code
  );

  modport slave (
    input  mon_rst, mon_enable, mon_direction, mon_count, clear,
    output locked, expected, err, err_pulse, err_count, err_code
  );
endinterface

// File: rtl/counter_monitor.sv
// Up/down counter observer: predicts each count from the previous sample and logs violations.
// Optional build macro COUNTER_MONITOR_NOWRAP_EN flags modulo wrap-around as a step error.
module counter_monitor #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
) (
  input logic               clk,
  input logic               rst_n,
  counter_monitor_if.slave  mon_bus
);

  typedef enum logic {ST_UNSYNC, ST_TRACK} state_t;

  localparam logic [1:0] CODE_RESET = 2'b01;
  localparam logic [1:0] CODE_HOLD  = 2'b10;
  localparam logic [1:0] CODE_STEP  = 2'b11;

  state_t               r_state;
  state_t               w_state_next;
  logic                 w_compare;
  logic                 w_locked;

  logic [WIDTH-1:0]     r_prev_count;
  logic                 r_prev_rst;
  logic                 r_prev_en;
  logic                 r_prev_dir;

  logic [WIDTH-1:0]     w_predict;
  logic                 w_mismatch;
  logic                 w_wrap;
  logic                 w_violation;
  logic [1:0]           w_code;

  logic                 r_err;
  logic                 r_err_pulse;
  logic [ERR_CNT_W-1:0] r_err_count;
  logic [1:0]           r_err_code;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_UNSYNC;
    else        r_state <= w_state_next;
  end

  // UNSYNC only captures the reference sample; checking starts in TRACK.
  always_comb begin
    w_state_next = r_state;
    w_compare    = 1'b0;
    w_locked     = 1'b0;
    case (r_state)
      ST_UNSYNC: w_state_next = ST_TRACK;
      ST_TRACK: begin
        w_compare = 1'b1;
        w_locked  = 1'b1;
      end
      default: w_state_next = ST_UNSYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev_count <= '0;
      r_prev_rst   <= 1'b0;
      r_prev_en    <= 1'b0;
      r_prev_dir   <= 1'b0;
    end else begin
      r_prev_count <= mon_bus.mon_count;
      r_prev_rst   <= mon_bus.mon_rst;
      r_prev_en    <= mon_bus.mon_enable;
      r_prev_dir   <= mon_bus.mon_direction;
    end
  end

  always_comb begin
    if (r_prev_rst)      w_predict = '0;
    else if (!r_prev_en) w_predict = r_prev_count;
    else if (r_prev_dir) w_predict = r_prev_count + 1'b1;
    else                 w_predict = r_prev_count - 1'b1;
  end

  always_comb begin
    if (r_prev_rst)      w_code = CODE_RESET;
    else if (!r_prev_en) w_code = CODE_HOLD;
    else                 w_code = CODE_STEP;
  end

  assign w_mismatch = (mon_bus.mon_count != w_predict);

`ifdef COUNTER_MONITOR_NOWRAP_EN
  // A legal wrap still matches the prediction, so it is caught from the prior sample alone.
  assign w_wrap = r_prev_en && !r_prev_rst &&
                  (( r_prev_dir && (r_prev_count == {WIDTH{1'b1}})) ||
                   (!r_prev_dir && (r_prev_count == '0)));
`else
  assign w_wrap = 1'b0;
`endif

  assign w_violation = w_compare && (w_mismatch || w_wrap);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err       <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_err_code  <= 2'b00;
    end else if (mon_bus.clear) begin
      r_err       <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
      r_err_code  <= 2'b00;
    end else if (w_violation) begin
      r_err       <= 1'b1;
      r_err_pulse <= 1'b1;
      if (r_err_count != {ERR_CNT_W{1'b1}}) r_err_count <= r_err_count + 1'b1;
      if (!r_err) r_err_code <= w_code;
    end else begin
      r_err_pulse <= 1'b0;
    end
  end

  assign mon_bus.locked    = w_locked;
  assign mon_bus.expected  = w_locked ? w_predict : '0;
  assign mon_bus.err       = r_err;
  assign mon_bus.err_pulse = r_err_pulse;
  assign mon_bus.err_count = r_err_count;
  assign mon_bus.err_code  = r_err_code;

endmodule
